// File: rtl/mips_mem_pkg.sv
// Shared constants for the load/store request unit: op codes, FSM state encoding,
// lane widths and the natural-alignment test.
`timescale 1ns/1ps
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [3:0] OP_LW  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LHU = 4'h2;
  localparam logic [3:0] OP_LB  = 4'h3;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_SW  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SB  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends load lanes, and builds the
// write word for SW (whole word) or SB/SH (one lane replaced in word_i).
`timescale 1ns/1ps
module lsu_lane
  import mips_mem_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  // Load lane selection and sign/zero extension
  always_comb begin
    byte_s = word_i[{addr_lo_i, 3'b000} +: BYTE_W];
    half_s = addr_lo_i[1] ? word_i[WORD_W-1:HALF_W] : word_i[HALF_W-1:0];
    case (op_i)
      OP_LW:   load_o = word_i;
      OP_LH:   load_o = {{(WORD_W-HALF_W){half_s[HALF_W-1]}}, half_s};
      OP_LHU:  load_o = {{(WORD_W-HALF_W){1'b0}}, half_s};
      OP_LB:   load_o = {{(WORD_W-BYTE_W){byte_s[BYTE_W-1]}}, byte_s};
      OP_LBU:  load_o = {{(WORD_W-BYTE_W){1'b0}}, byte_s};
      default: load_o = {WORD_W{1'b0}};
    endcase
  end

  // Store word: only the addressed lane of the old word is replaced
  always_comb begin
    merge_o = word_i;
    case (op_i)
      OP_SW: merge_o = wdata_i;
      OP_SH: begin
        if (addr_lo_i[1]) merge_o[WORD_W-1:HALF_W] = wdata_i[HALF_W-1:0];
        else              merge_o[HALF_W-1:0]      = wdata_i[HALF_W-1:0];
      end
      OP_SB:   merge_o[{addr_lo_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_req.sv
// MEM-stage load/store request FSM (IDLE/ACCESS/MERGE/RESP), sub-word stores by
// read-modify-write. Define LSU_ALIGN_CHECK_EN to report misaligned accesses.
`timescale 1ns/1ps
module lsu_req
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] lane_word_s, load_s, merge_s;
  logic              mis_s, sub_store_s;

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign mis_s    = is_misaligned(op_q, addr_q[1:0]);
  assign resp_err = err_q;

  // Misalignment flag captured in ACCESS, presented with the response
  always_comb begin
    err_d = err_q;
    if (state_q == ST_ACCESS) err_d = mis_s;
    else                      err_d = err_q;
  end

  // Error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign mis_s    = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign sub_store_s = (op_q == OP_SB) || (op_q == OP_SH);
  assign lane_word_s = (state_q == ST_MERGE) ? word_q : mem_rdata;
  assign mem_addr    = addr_q[ADDR_W-1:2];
  assign resp_rdata  = rdata_q;

  lsu_lane u_lane (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (lane_word_s),
    .wdata_i   (wdata_q),
    .load_o    (load_s),
    .merge_o   (merge_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_ACCESS;
        else           state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        if (sub_store_s && !mis_s) state_d = ST_MERGE;
        else                       state_d = ST_RESP;
      end
      ST_MERGE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; writes happen only in ACCESS (SW) or MERGE (SB/SH)
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        if ((op_q == OP_SW) && !mis_s) begin
          mem_we    = 1'b1;
          mem_wdata = merge_s;
        end else begin
          mem_we    = 1'b0;
        end
      end
      ST_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merge_s;
      end
      ST_RESP: resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request capture on accept, memory word and load result capture in ACCESS
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      op_d    = req_op;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end else if (state_q == ST_ACCESS) begin
      word_d  = mem_rdata;
      rdata_d = mis_s ? {DATA_W{1'b0}} : load_s;
    end else begin
      word_d  = word_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 4'h0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      word_q  <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_req.sv
// Directed, table-driven bench for lsu_req with a small word memory model.
`timescale 1ns/1ps
module tb_lsu_req;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'h0;
  int          we_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  lsu_req dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    int          exp_lat;
    logic        exp_err;
    int          exp_we;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] init, input logic [31:0] rdata, input logic [31:0] word,
                              input int lat, input logic err, input int we);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.init = init; v.exp_rdata = rdata;
    v.exp_word = word; v.exp_lat = lat; v.exp_err = err; v.exp_we = we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int cyc;
    int w0;
    v = vecs[i];
    preload(v.addr[7:2], v.init);
    w0 = we_cnt;
    req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d_latency", i), cyc, v.exp_lat);
    chk($sformatf("v%0d_rdata", i), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", i), {31'd0, resp_err}, {31'd0, v.exp_err});
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", i), {31'd0, resp_valid}, 32'd0);
    chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d_we_count", i), we_cnt - w0, v.exp_we);
    chk($sformatf("v%0d_mem_word", i), mem[v.addr[7:2]], v.exp_word);
  endtask

  initial begin
    int w0;
    vecs[0]  = mk(OP_LW,  32'h10, 32'h0,        32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 2, 1'b0, 0);
    vecs[1]  = mk(OP_LB,  32'h13, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 32'h80FF1234, 2, 1'b0, 0);
    vecs[2]  = mk(OP_LBU, 32'h13, 32'h0,        32'h80FF1234, 32'h00000080, 32'h80FF1234, 2, 1'b0, 0);
    vecs[3]  = mk(OP_LH,  32'h12, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 32'h80FF1234, 2, 1'b0, 0);
    vecs[4]  = mk(OP_LHU, 32'h12, 32'h0,        32'h80FF1234, 32'h000080FF, 32'h80FF1234, 2, 1'b0, 0);
    vecs[5]  = mk(OP_LB,  32'h10, 32'h0,        32'h80FF1234, 32'h00000034, 32'h80FF1234, 2, 1'b0, 0);
    vecs[6]  = mk(OP_LH,  32'h10, 32'h0,        32'h80FF9234, 32'hFFFF9234, 32'h80FF9234, 2, 1'b0, 0);
    vecs[7]  = mk(OP_SW,  32'h20, 32'hDEADBEEF, 32'h11223344, 32'h0,        32'hDEADBEEF, 2, 1'b0, 1);
    vecs[8]  = mk(OP_SB,  32'h21, 32'h000000CD, 32'h11223344, 32'h0,        32'h1122CD44, 3, 1'b0, 1);
    vecs[9]  = mk(OP_SH,  32'h22, 32'h9999ABCD, 32'h11223344, 32'h0,        32'hABCD3344, 3, 1'b0, 1);
    vecs[10] = mk(OP_SB,  32'h23, 32'hFFFFFFEE, 32'h11223344, 32'h0,        32'hEE223344, 3, 1'b0, 1);
    vecs[11] = mk(4'hF,   32'h14, 32'h12345678, 32'h55555555, 32'h0,        32'h55555555, 2, 1'b0, 0);
`ifdef LSU_ALIGN_CHECK_EN
    vecs[12] = mk(OP_SH,  32'h01, 32'h0000BEEF, 32'h11223344, 32'h0,        32'h11223344, 2, 1'b1, 0);
    vecs[13] = mk(OP_LW,  32'h12, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 2, 1'b1, 0);
`else
    vecs[12] = mk(OP_SH,  32'h01, 32'h0000BEEF, 32'h11223344, 32'h0,        32'h1122BEEF, 3, 1'b0, 1);
    vecs[13] = mk(OP_LW,  32'h12, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2, 1'b0, 0);
`endif

    #12;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", {31'd0, resp_err}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(i);

    // Reset while an SB is in MERGE: the pending write must be dropped
    preload(6'd12, 32'hA5A5A5A5);
    req_op = OP_SB; req_addr = 32'h30; req_wdata = 32'h00000011; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("merge_we", {31'd0, mem_we}, 32'd1);
    chk("merge_wdata", mem_wdata, 32'hA5A5A511);
    w0 = we_cnt;
    rst = 1'b1;
    #1;
    chk("rst_merge_we", {31'd0, mem_we}, 32'd0);
    chk("rst_merge_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_merge_word", mem[12], 32'hA5A5A5A5);
    chk("rst_merge_we_count", we_cnt - w0, 32'd0);
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_release_resp", {31'd0, resp_valid}, 32'd0);

    // Back-to-back requests held on req_valid
    preload(6'd4, 32'h8899AABB);
    req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ready_t1", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp_t2", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdata1", resp_rdata, 32'h8899AABB);
    chk("b2b_ready_t2", {31'd0, req_ready}, 32'd0);
    req_op = OP_LBU; req_addr = 32'h11;
    @(posedge clk); #1;
    chk("b2b_ready_t3", {31'd0, req_ready}, 32'd1);
    chk("b2b_resp_t3", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_ready_t4", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdata2", resp_rdata, 32'h000000AA);
    @(posedge clk); #1;
    chk("b2b_ready_end", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
